// File: rtl/pc_gen_pkg.sv
// pc_gen_pkg: shared constants, counter encodings and counter update helper for the fetch-address generator
package pc_gen_pkg;

    localparam int DEF_ADDR_WIDTH = 32;
    localparam logic STOP = 1'b1;

    typedef logic [1:0] cnt_t;

    localparam cnt_t CNT_SNT = 2'b00;
    localparam cnt_t CNT_WNT = 2'b01;
    localparam cnt_t CNT_WT  = 2'b10;
    localparam cnt_t CNT_ST  = 2'b11;

    function automatic cnt_t cnt_step(cnt_t c, logic taken);
        return taken ? (c == CNT_ST ? c : c + 2'd1) : (c == CNT_SNT ? c : c - 2'd1);
    endfunction

endpackage

// File: rtl/pc_btb.sv
// pc_btb: direct-mapped branch target buffer with 2-bit counters, one lookup and one update port
module pc_btb
    import pc_gen_pkg::*;
#(
    parameter int AW    = DEF_ADDR_WIDTH,
    parameter int DEPTH = 8
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [AW-1:2] pc,
    output logic          hit_taken,
    output logic [AW-1:0] target,
    input  logic          upd_valid,
    input  logic [AW-1:2] upd_pc,
    input  logic [AW-1:0] upd_target,
    input  logic          upd_taken
);
    localparam int IDX_W = $clog2(DEPTH);
    localparam int TAG_W = AW - IDX_W - 2;

    logic [DEPTH-1:0] valid;
    logic [TAG_W-1:0] tags [DEPTH];
    logic [AW-1:0]    targets [DEPTH];
    cnt_t             cnts [DEPTH];
    logic [IDX_W-1:0] idx, uidx;
    logic [TAG_W-1:0] tag, utag;
    logic             uhit;

    assign idx       = pc[IDX_W+1:2];
    assign tag       = pc[AW-1:IDX_W+2];
    assign uidx      = upd_pc[IDX_W+1:2];
    assign utag      = upd_pc[AW-1:IDX_W+2];
    assign hit_taken = valid[idx] && tags[idx] == tag && cnts[idx] >= CNT_WT;
    assign target    = targets[idx];
    assign uhit      = valid[uidx] && tags[uidx] == utag;

    // Valid bits: cleared by reset, set when a taken branch allocates a missing entry
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            valid <= '0;
        else if (upd_valid && upd_taken && !uhit)
            valid[uidx] <= 1'b1;
    end

    // Entry payload: hits train the counter (target refreshed on taken), taken misses allocate weak-taken
    always_ff @(posedge clk) begin
        if (upd_valid && (uhit || upd_taken)) begin
            tags[uidx] <= utag;
            cnts[uidx] <= uhit ? cnt_step(cnts[uidx], upd_taken) : CNT_WT;
            if (upd_taken)
                targets[uidx] <= upd_target & ~AW'(3);
        end
    end

endmodule

// File: rtl/pc_gen.sv
// pc_gen: IF-stage fetch address generator with redirects, sticky stalled redirects and BTB prediction
module pc_gen
    import pc_gen_pkg::*;
#(
    parameter int                    ADDR_WIDTH   = DEF_ADDR_WIDTH,
    parameter logic [ADDR_WIDTH-1:0] RESET_VECTOR = '0,
    parameter int                    BTB_DEPTH    = 8
) (
    input  logic                  clk_i,
    input  logic                  rst_i,
    input  logic [5:0]            stall_i,
    input  logic                  trap_i,
    input  logic [ADDR_WIDTH-1:0] trap_pc_i,
    input  logic                  flush_jump_i,
    input  logic [ADDR_WIDTH-1:0] new_pc_i,
    input  logic                  upd_valid_i,
    input  logic [ADDR_WIDTH-1:0] upd_pc_i,
    input  logic [ADDR_WIDTH-1:0] upd_target_i,
    input  logic                  upd_taken_i,
    output logic [ADDR_WIDTH-1:0] pc_o,
    output logic                  ce_o,
    output logic                  pred_taken_o
);
    localparam logic [ADDR_WIDTH-1:0] MASK = ~ADDR_WIDTH'(3);

    logic                  stop, redirect, pend_valid, btb_taken, unused_stall;
    logic [ADDR_WIDTH-1:0] redir_pc, pend_pc, btb_target, next_pc;

    assign stop         = stall_i[0] == STOP;
    assign unused_stall = ^stall_i[5:1];
    assign redirect     = trap_i | flush_jump_i;
    assign redir_pc     = (trap_i ? trap_pc_i : new_pc_i) & MASK;
    assign pred_taken_o = ce_o & btb_taken;

    pc_btb #(.AW(ADDR_WIDTH), .DEPTH(BTB_DEPTH)) u_btb (
        .clk        (clk_i),
        .rst        (rst_i),
        .pc         (pc_o[ADDR_WIDTH-1:2]),
        .hit_taken  (btb_taken),
        .target     (btb_target),
        .upd_valid  (upd_valid_i),
        .upd_pc     (upd_pc_i[ADDR_WIDTH-1:2]),
        .upd_target (upd_target_i),
        .upd_taken  (upd_taken_i)
    );

    // Next-PC priority: redirect, stall hold, pending redirect, predicted target, sequential
    always_comb begin
        next_pc = redirect ? redir_pc :
                  stop ? pc_o :
                  pend_valid ? pend_pc :
                  pred_taken_o ? btb_target : pc_o + ADDR_WIDTH'(4);
    end

    // PC, fetch enable and pending redirect; a redirect taken under stall stays pending until release
    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            ce_o       <= 1'b0;
            pc_o       <= RESET_VECTOR & MASK;
            pend_valid <= 1'b0;
            pend_pc    <= '0;
        end else if (!ce_o) begin
            ce_o <= 1'b1;
        end else begin
            pc_o <= next_pc;
            if (redirect) begin
                pend_pc    <= redir_pc;
                pend_valid <= stop;
            end else if (!stop) begin
                pend_valid <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_pc_gen.sv
// tb_pc_gen: directed vector table plus randomized run against a behavioural fetch-address model
module tb_pc_gen;
    localparam int          AW = 32;
    localparam logic [31:0] RV = 32'h100;
    localparam int          D  = 8;
    localparam int          IW = 3;
    localparam int          NV = 25;

    logic        clk = 1'b0, rst = 1'b1;
    logic [5:0]  stall = '0;
    logic        trap = 0, flush = 0, uv = 0, ut = 0;
    logic [31:0] trap_pc = '0, new_pc = '0, upc = '0, utgt = '0;
    logic [31:0] pc;
    logic        ce, pred;

    int checks = 0, failures = 0;

    // behavioural model state
    logic        m_ce, m_pv;
    logic [31:0] m_pc, m_pp;
    logic        m_val [D];
    logic [31:0] m_tag [D];
    logic [31:0] m_tgt [D];
    int          m_cnt [D];

    typedef struct {
        logic        stall;
        logic        trap;
        logic [31:0] tpc;
        logic        flush;
        logic [31:0] npc;
        logic        uv;
        logic [31:0] upc;
        logic [31:0] utgt;
        logic        ut;
        logic [31:0] epc;
        logic        ece;
        logic        epred;
    } vec_t;

    vec_t vecs [NV];

    pc_gen #(.ADDR_WIDTH(AW), .RESET_VECTOR(RV), .BTB_DEPTH(D)) dut (
        .clk_i        (clk),
        .rst_i        (rst),
        .stall_i      (stall),
        .trap_i       (trap),
        .trap_pc_i    (trap_pc),
        .flush_jump_i (flush),
        .new_pc_i     (new_pc),
        .upd_valid_i  (uv),
        .upd_pc_i     (upc),
        .upd_target_i (utgt),
        .upd_taken_i  (ut),
        .pc_o         (pc),
        .ce_o         (ce),
        .pred_taken_o (pred)
    );

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish, got stuck, required finish");
        $fatal(1, "timeout");
    end

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    function automatic int idx_of(input logic [31:0] a);
        return int'((a >> 2) % D);
    endfunction

    function automatic logic [31:0] tag_of(input logic [31:0] a);
        return a >> (2 + IW);
    endfunction

    function automatic logic m_hit(input logic [31:0] a);
        return m_val[idx_of(a)] && m_tag[idx_of(a)] == tag_of(a);
    endfunction

    function automatic logic m_pred();
        return m_ce && m_hit(m_pc) && m_cnt[idx_of(m_pc)] >= 2;
    endfunction

    task automatic model_reset();
        m_ce = 0;
        m_pv = 0;
        m_pp = '0;
        m_pc = RV & ~32'h3;
        for (int i = 0; i < D; i++) m_val[i] = 0;
    endtask

    task automatic model_check(input string tag);
        chk({tag, "_pc"}, pc, m_pc);
        chk({tag, "_ce"}, 32'(ce), 32'(m_ce));
        chk({tag, "_pred"}, 32'(pred), 32'(m_pred()));
    endtask

    // advance one clock: model computes its next state from the current inputs, then both step
    task automatic tick();
        logic [31:0] npc, npp;
        logic        nce, npv;
        int          ui;
        npc = m_pc;
        npp = m_pp;
        nce = m_ce;
        npv = m_pv;
        if (!m_ce) nce = 1;
        else if (trap || flush) begin
            npc = (trap ? trap_pc : new_pc) & ~32'h3;
            npp = npc;
            npv = stall[0];
        end else if (stall[0]) begin
        end else if (m_pv) begin
            npc = m_pp;
            npv = 0;
        end else if (m_pred()) npc = m_tgt[idx_of(m_pc)];
        else npc = m_pc + 32'd4;
        ui = idx_of(upc);
        @(posedge clk);
        if (uv) begin
            if (m_hit(upc)) begin
                m_cnt[ui] = ut ? (m_cnt[ui] == 3 ? 3 : m_cnt[ui] + 1) : (m_cnt[ui] == 0 ? 0 : m_cnt[ui] - 1);
                if (ut) m_tgt[ui] = utgt & ~32'h3;
            end else if (ut) begin
                m_val[ui] = 1;
                m_tag[ui] = tag_of(upc);
                m_tgt[ui] = utgt & ~32'h3;
                m_cnt[ui] = 2;
            end
        end
        m_pc = npc;
        m_pp = npp;
        m_ce = nce;
        m_pv = npv;
        @(negedge clk);
    endtask

    task automatic mid_reset(input string tag);
        #2 rst = 1;
        #1;
        chk({tag, "_rst_ce"}, 32'(ce), 32'h0);
        chk({tag, "_rst_pc"}, pc, RV);
        chk({tag, "_rst_pred"}, 32'(pred), 32'h0);
        model_reset();
    endtask

    function automatic logic [31:0] rand_addr();
        logic [31:0] base;
        base = $urandom_range(0, 1) ? 32'h0 : 32'hFFFF_FF00;
        return base + 32'($urandom_range(0, 63) << 2) + 32'($urandom_range(0, 3));
    endfunction

    function automatic vec_t mk(input logic s, input logic t, input logic [31:0] tp, input logic f,
                                input logic [31:0] np, input logic v, input logic [31:0] up,
                                input logic [31:0] ug, input logic tk, input logic [31:0] ep,
                                input logic ec, input logic epr);
        vec_t r;
        r = '{s, t, tp, f, np, v, up, ug, tk, ep, ec, epr};
        return r;
    endfunction

    initial begin
        vecs[0]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 1, 0);
        vecs[1]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h104, 1, 0);
        vecs[2]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h108, 1, 0);
        vecs[3]  = mk(1, 0, 0, 1, 32'h2000, 0, 0, 0, 0, 32'h2000, 1, 0);
        vecs[4]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2000, 1, 0);
        vecs[5]  = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2000, 1, 0);
        vecs[6]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2000, 1, 0);
        vecs[7]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h2004, 1, 0);
        vecs[8]  = mk(0, 1, 32'h80, 1, 32'h400, 0, 0, 0, 0, 32'h80, 1, 0);
        vecs[9]  = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h84, 1, 0);
        vecs[10] = mk(0, 1, 32'h40, 0, 0, 1, 32'h40, 32'h200, 1, 32'h40, 1, 1);
        vecs[11] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h200, 1, 0);
        vecs[12] = mk(0, 1, 32'h40, 0, 0, 1, 32'h40, 32'h200, 0, 32'h40, 1, 0);
        vecs[13] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h44, 1, 0);
        vecs[14] = mk(0, 0, 0, 0, 0, 1, 32'h40, 32'h200, 1, 32'h48, 1, 0);
        vecs[15] = mk(0, 0, 0, 0, 0, 1, 32'h40, 32'h200, 1, 32'h4C, 1, 0);
        vecs[16] = mk(0, 1, 32'h40, 0, 0, 1, 32'h40, 32'h200, 0, 32'h40, 1, 1);
        vecs[17] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h200, 1, 0);
        vecs[18] = mk(0, 1, 32'h40 + 4 * D, 0, 0, 0, 0, 0, 0, 32'h60, 1, 0);
        vecs[19] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h64, 1, 0);
        vecs[20] = mk(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0, 32'hFFFF_FFFC, 1, 0);
        vecs[21] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h0, 1, 0);
        vecs[22] = mk(0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 32'h40, 1, 1);
        vecs[23] = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 32'h100, 1, 0);
        vecs[24] = mk(0, 1, 32'h40, 0, 0, 0, 0, 0, 0, 32'h40, 1, 0);

        model_reset();
        #12;
        chk("reset_ce", 32'(ce), 32'h0);
        chk("reset_pc", pc, RV);
        chk("reset_pred", 32'(pred), 32'h0);
        @(negedge clk);
        rst = 0;

        for (int i = 0; i < NV; i++) begin
            if (i == 23) begin
                mid_reset("dir");
                @(negedge clk);
                rst = 0;
            end
            stall   = {5'b0, vecs[i].stall};
            trap    = vecs[i].trap;
            trap_pc = vecs[i].tpc;
            flush   = vecs[i].flush;
            new_pc  = vecs[i].npc;
            uv      = vecs[i].uv;
            upc     = vecs[i].upc;
            utgt    = vecs[i].utgt;
            ut      = vecs[i].ut;
            tick();
            chk($sformatf("row%0d_pc", i), pc, vecs[i].epc);
            chk($sformatf("row%0d_ce", i), 32'(ce), 32'(vecs[i].ece));
            chk($sformatf("row%0d_pred", i), 32'(pred), 32'(vecs[i].epred));
            model_check($sformatf("row%0d_model", i));
        end

        for (int c = 0; c < 3000; c++) begin
            stall   = {6'($urandom_range(0, 31)) << 1} | 6'($urandom_range(0, 3) == 0);
            trap    = $urandom_range(0, 15) == 0;
            flush   = $urandom_range(0, 9) == 0;
            trap_pc = rand_addr();
            new_pc  = rand_addr();
            uv      = $urandom_range(0, 1) == 1;
            upc     = rand_addr();
            utgt    = rand_addr();
            ut      = $urandom_range(0, 2) != 0;
            if ($urandom_range(0, 299) == 0) begin
                mid_reset("rnd");
                #1 rst = 0;
            end
            tick();
            model_check("rnd");
        end

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/pc_gen.md
# pc_gen

Parametrised fetch-address generator for the IF stage, the next generation of the single-register PC. It produces the instruction fetch address and enable each cycle, supports a configurable reset vector, and accepts trap and jump redirects. A redirect that arrives during a stall is held and applied when the stall releases, so it is never lost. A small direct-mapped branch target buffer (BTB) with 2-bit counters predicts taken branches, and the execute stage trains it.

## Interface
- ADDR_WIDTH, 32: fetch address width.
- RESET_VECTOR, 32'h0: first fetch address after reset.
- BTB_DEPTH, 8: number of BTB entries; power of two, ≥2; IDX_W = log2(BTB_DEPTH).
- clk_i  in  1  the single clock.
- rst_i  in  1  reset, asynchronous and active-high.
- stall_i  in  6  pipeline stall vector; bit 0 == `STOP freezes the PC.
- trap_i  in  1  trap redirect request.
- trap_pc_i  in  ADDR_WIDTH  trap handler address.
- flush_jump_i  in  1  jump/branch-mispredict redirect request.
- new_pc_i  in  ADDR_WIDTH  redirect target for flush_jump_i.
- upd_valid_i  in  1  BTB training strobe from EX.
- upd_pc_i  in  ADDR_WIDTH  address of the resolved branch.
- upd_target_i  in  ADDR_WIDTH  resolved branch target.
- upd_taken_i  in  1  resolved direction.
- pc_o  out  ADDR_WIDTH  current fetch address.
- ce_o  out  1  fetch enable.
- pred_taken_o  out  1  pc_o is predicted taken; this is the BTB lookup of pc_o.

## Operation
- All loaded addresses have bits [1:0] forced to 0. The sequential increment is +4 modulo 2^ADDR_WIDTH, so 0xFFFF_FFFC wraps to 0x0.
- **Reset state.** rst_i asserted clears asynchronously: ce_o=0, pc_o=RESET_VECTOR, pending_valid=0, all BTB valid bits=0. BTB targets and counters are not reset.
- **Fetch enable.** ce_o goes to 1 on the first clk_i edge with rst_i low. While ce_o=0, pc_o holds RESET_VECTOR.
- **Next-PC priority** (ce_o=1), highest first:
  1. trap_i loads trap_pc_i.
  2. flush_jump_i loads new_pc_i.
  3. stall_i[0]==`STOP holds pc_o.
  4. pending_valid loads pending_pc and clears pending_valid.
  5. BTB predict-taken loads the BTB target.
  6. Otherwise pc_o+4.
- **Redirect during stall.** The redirect is still applied to pc_o; stall does not block it.
- **Pending redirect.** A redirect arriving while stall_i[0]==`STOP is also recorded in pending_pc/pending_valid. This keeps the redirect target sticky: any stall-hold cycles afterwards keep pc_o on that target, and after the stall releases fetch resumes from it. A later trap overwrites the pending entry, and so does a later flush.
- **BTB lookup** (combinational on pc_o):
  - index = pc_o[IDX_W+1:2]; tag = pc_o[ADDR_WIDTH-1:IDX_W+2].
  - Hit = entry valid and tag equal.
  - pred_taken_o = hit and counter ≥ 2, gated by ce_o.
- **BTB update** (clock edge, upd_valid_i=1):
  - Hit: counter saturating +1 if taken, −1 if not taken. Target is rewritten when taken.
  - Miss and taken: allocate the entry with tag, target, counter=2, valid=1.
  - Miss and not taken: no change.
- The BTB updates even during stall.

## Timing
- Registered pc_o; each decision takes effect on the next edge.
- Redirect latency: request in cycle N gives pc_o = target in cycle N+1.
- Lookup and update on the same index in the same cycle: the lookup sees the old entry. The new entry is visible from the next cycle.
- trap_i and flush_jump_i asserted together: the trap wins, and new_pc_i is discarded.
- Reset asserted mid-operation: outputs return to their reset values immediately, not waiting for a clock edge.
- Any predicted-taken flag emitted while ce_o=0 is 0.

## Structure
- Shared package / defines.v holds `STOP, `ADDR_WIDTH and the counter encodings: 2'b00 strong-not-taken through 2'b11 strong-taken, weak-taken = 2'b10.
- Sub-module pc_btb contains:
  - the direct-mapped valid/tag/target/counter arrays;
  - the lookup port and the update port.
- pc_gen keeps:
  - ce_o and pc_o;
  - the pending-redirect register;
  - the priority mux.

## Test plan
- **Reset and release.** RESET_VECTOR=0x100; rst_i high, then low → ce_o=0 and pc_o=0x100, then ce_o=1, then pc_o=0x104, 0x108.
- **Stalled redirect.**
  - Stimulus: flush_jump_i with new_pc_i=0x2000 while stall_i[0]=`STOP for 3 cycles.
  - Response: pc_o=0x2000 after one edge, held through the stall, then 0x2004 after release.
- **Simultaneous redirects.** trap_i (trap_pc_i=0x80) together with flush_jump_i (new_pc_i=0x400) → pc_o=0x80; 0x400 never appears.
- **BTB allocate and predict.**
  - Train pc 0x40 taken with target 0x200.
  - Next fetch of 0x40 → pred_taken_o=1, then pc_o=0x200.
  - One not-taken update → the next fetch of 0x40 goes to 0x44.
- **Counter hysteresis and alias.**
  - Two taken updates, then one not-taken on 0x40 → still predicts taken.
  - Aliasing pc 0x40+4·BTB_DEPTH misses (pred_taken_o=0).
- **Async reset and wrap.**
  - rst_i pulse mid-cycle during a BTB-hit stream → ce_o=0 immediately and all predictions cleared.
  - With ce_o=1, stepping from pc 0xFFFF_FFFC → 0x0.
